// File: rtl/run_pkg.sv
// Shared types for the run sequencer: FSM state encoding and the
// halt opcode the decoder matches to raise Halt.
package run_pkg;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        RUN,
        DONE
    } run_state_t;

    localparam logic [8:0] HALT_OPCODE = 9'h1FF;

endpackage

// File: rtl/dmem_port_mux.sv
// DataMem port arbiter: core owns the port in RUN, host in IDLE/DONE,
// nobody in INIT. Registers host read data with a one-cycle valid.
// Ports: Clk, Reset (async, active-low), State (sequencer state),
//   Core* (core access), Host* (host access, grant, read return),
//   Mem* (to/from DataMem, combinational read data).
module dmem_port_mux
    import run_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  run_state_t    State,
    input  logic [AW-1:0] CoreMemAddr,
    input  logic          CoreMemWe,
    input  logic [DW-1:0] CoreMemWData,
    input  logic          HostReq,
    input  logic          HostWe,
    input  logic [AW-1:0] HostAddr,
    input  logic [DW-1:0] HostWData,
    output logic          HostGnt,
    output logic          HostRValid,
    output logic [DW-1:0] HostRData,
    output logic [AW-1:0] MemAddr,
    output logic          MemWe,
    output logic [DW-1:0] MemWData,
    input  logic [DW-1:0] MemRData
);

    logic core_own;
    logic host_own;
    logic host_rd;

    assign core_own = (State == RUN);
    assign host_own = (State == IDLE) || (State == DONE);
    // A host request outside the host window is simply not granted;
    // the host keeps it asserted until the window opens.
    assign HostGnt  = host_own & HostReq;
    assign host_rd  = HostGnt & ~HostWe;

    always_comb begin
        MemAddr  = '0;
        MemWe    = 1'b0;
        MemWData = '0;
        if (core_own) begin
            MemAddr  = CoreMemAddr;
            MemWe    = CoreMemWe;
            MemWData = CoreMemWData;
        end else if (host_own) begin
            MemAddr  = HostAddr;
            MemWe    = HostReq & HostWe;
            MemWData = HostWData;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            HostRValid <= 1'b0;
            HostRData  <= '0;
        end else begin
            HostRValid <= host_rd;
            if (host_rd) begin
                HostRData <= MemRData;
            end
        end
    end

endmodule

// File: rtl/run_sequencer.sv
// Run controller: Start -> PC init -> run -> halt -> Ack, with a cycle
// counter, watchdog and DataMem port sharing between core and host.
// Ports: Clk, Reset (async, active-low), Start, Halt, PcInit, CoreRun,
//   Ack, Timeout, CycleCt, Core*/Host*/Mem* (see dmem_port_mux).
module run_sequencer
    import run_pkg::*;
#(
    parameter int            AW         = 8,
    parameter int            DW         = 8,
    parameter int            CW         = 16,
    parameter logic [CW-1:0] MAX_CYCLES = 16'hFFF0
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Halt,
    output logic          PcInit,
    output logic          CoreRun,
    output logic          Ack,
    output logic          Timeout,
    output logic [CW-1:0] CycleCt,
    input  logic [AW-1:0] CoreMemAddr,
    input  logic          CoreMemWe,
    input  logic [DW-1:0] CoreMemWData,
    input  logic          HostReq,
    input  logic          HostWe,
    input  logic [AW-1:0] HostAddr,
    input  logic [DW-1:0] HostWData,
    output logic          HostGnt,
    output logic          HostRValid,
    output logic [DW-1:0] HostRData,
    output logic [AW-1:0] MemAddr,
    output logic          MemWe,
    output logic [DW-1:0] MemWData,
    input  logic [DW-1:0] MemRData
);

    // Count value at the start of the last allowed RUN cycle; the
    // increment on that cycle lands exactly on MAX_CYCLES, never past.
    localparam logic [CW-1:0] LAST_CT = MAX_CYCLES - 1'b1;

    run_state_t state;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            PcInit  <= 1'b0;
            CoreRun <= 1'b0;
            Ack     <= 1'b0;
            Timeout <= 1'b0;
            CycleCt <= '0;
        end else if (Start) begin
            // Start overrides halt and watchdog in every state.
            state   <= INIT;
            PcInit  <= 1'b1;
            CoreRun <= 1'b0;
            Ack     <= 1'b0;
            Timeout <= 1'b0;
            CycleCt <= '0;
        end else begin
            unique case (state)
                INIT: begin
                    state   <= RUN;
                    PcInit  <= 1'b0;
                    CoreRun <= 1'b1;
                end
                RUN: begin
                    CycleCt <= CycleCt + 1'b1;
                    if (Halt) begin
                        state   <= DONE;
                        CoreRun <= 1'b0;
                        Ack     <= 1'b1;
                    end else if (CycleCt == LAST_CT) begin
                        state   <= DONE;
                        CoreRun <= 1'b0;
                        Ack     <= 1'b1;
                        Timeout <= 1'b1;
                    end
                end
                IDLE, DONE: begin
                end
            endcase
        end
    end

    dmem_port_mux #(
        .AW (AW),
        .DW (DW)
    ) u_mux (
        .Clk          (Clk),
        .Reset        (Reset),
        .State        (state),
        .CoreMemAddr  (CoreMemAddr),
        .CoreMemWe    (CoreMemWe),
        .CoreMemWData (CoreMemWData),
        .HostReq      (HostReq),
        .HostWe       (HostWe),
        .HostAddr     (HostAddr),
        .HostWData    (HostWData),
        .HostGnt      (HostGnt),
        .HostRValid   (HostRValid),
        .HostRData    (HostRData),
        .MemAddr      (MemAddr),
        .MemWe        (MemWe),
        .MemWData     (MemWData),
        .MemRData     (MemRData)
    );

endmodule
